// File: rtl/sonar_counter_pkg.sv
//------------------------------------------------------------------------------
// sonar_counter_pkg
// Shared constants for the SONAR timing and sample-index counters.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sonar_counter_pkg;

  localparam logic CNT_MODE_WRAP     = 1'b0;
  localparam logic CNT_MODE_SAT      = 1'b1;
  localparam int   CNT_DEFAULT_WIDTH = 6;

  // Any non-zero SATURATE parameter selects hold-at-boundary behaviour.
  function automatic logic cnt_mode_from_param(input int saturate);
    return (saturate != 0) ? CNT_MODE_SAT : CNT_MODE_WRAP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_next_value.sv
//------------------------------------------------------------------------------
// counter_next_value
// Combinational next-count and boundary detection for one counting step.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_next_value
  import sonar_counter_pkg::*;
#(
  parameter int WIDTH = CNT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic [WIDTH-1:0] max_value,
  input  logic             mode,
  output logic [WIDTH-1:0] next_q,
  output logic             at_boundary
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_q      = q;
    at_boundary = 1'b0;
    if (up) begin
      // A loaded value above max_value is also treated as the boundary.
      if (q >= max_value) begin
        at_boundary = 1'b1;
        next_q      = (mode == CNT_MODE_SAT) ? q : '0;
      end else begin
        next_q = q + C_ONE;
      end
    end else begin
      if (q == '0) begin
        at_boundary = 1'b1;
        next_q      = (mode == CNT_MODE_SAT) ? '0 : max_value;
      end else begin
        next_q = q - C_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_n_enable.sv
//------------------------------------------------------------------------------
// counter_n_enable
// Parametrised up/down counter with enable, load, clear, tc pulse and sticky overflow.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_n_enable
  import sonar_counter_pkg::*;
#(
  parameter int WIDTH    = CNT_DEFAULT_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             overflow
);

  localparam logic C_MODE = cnt_mode_from_param(SATURATE);

  logic [WIDTH-1:0] step_q;
  logic             step_boundary;

  counter_next_value #(
    .WIDTH (WIDTH)
  ) u_next (
    .q           (q),
    .up          (up),
    .max_value   (max_value),
    .mode        (C_MODE),
    .next_q      (step_q),
    .at_boundary (step_boundary)
  );

  // Priority: reset > clear > load > enable > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      q        <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      q  <= load_value;
      tc <= 1'b0;
    end else if (enable) begin
      q        <= step_q;
      tc       <= step_boundary;
      overflow <= overflow | step_boundary;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_n_enable.sv
//------------------------------------------------------------------------------
// tb_counter_n_enable
// Scoreboard bench for a 6-bit wrapping and an 8-bit saturating counter.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_n_enable;

  typedef struct packed {
    logic [5:0] q;
    logic       tc;
    logic       ov;
  } exp_a_t;

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
    logic       ov;
  } exp_b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=6, wrap
  logic       a_reset = 1'b1, a_enable = 1'b0, a_clear = 1'b0, a_load = 1'b0, a_up = 1'b1;
  logic [5:0] a_load_value = '0, a_max = 6'd63, a_q;
  logic       a_tc, a_overflow;

  // Instance B: WIDTH=8, saturate
  logic       b_reset = 1'b1, b_enable = 1'b0, b_clear = 1'b0, b_load = 1'b0, b_up = 1'b1;
  logic [7:0] b_load_value = '0, b_max = 8'd200, b_q;
  logic       b_tc, b_overflow;

  counter_n_enable #(.WIDTH(6), .SATURATE(0)) dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .clear(a_clear), .load(a_load),
    .load_value(a_load_value), .up(a_up), .max_value(a_max),
    .q(a_q), .tc(a_tc), .overflow(a_overflow)
  );

  counter_n_enable #(.WIDTH(8), .SATURATE(1)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .clear(b_clear), .load(b_load),
    .load_value(b_load_value), .up(b_up), .max_value(b_max),
    .q(b_q), .tc(b_tc), .overflow(b_overflow)
  );

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];
  string  tag_a[$];
  string  tag_b[$];
  int     tests = 0;
  int     fails = 0;

  // Monitor: registered outputs are valid one step after each posedge.
  always @(posedge clk) begin
    #1;
    if (sb_a.size() != 0) begin
      exp_a_t e;
      string  t;
      e = sb_a.pop_front();
      t = tag_a.pop_front();
      tests++;
      if ({a_q, a_tc, a_overflow} !== e) begin
        fails++;
        $display("FAIL %s: got q=%0d tc=%0b ov=%0b, expected q=%0d tc=%0b ov=%0b",
                 t, a_q, a_tc, a_overflow, e.q, e.tc, e.ov);
      end
    end
    if (sb_b.size() != 0) begin
      exp_b_t e;
      string  t;
      e = sb_b.pop_front();
      t = tag_b.pop_front();
      tests++;
      if ({b_q, b_tc, b_overflow} !== e) begin
        fails++;
        $display("FAIL %s: got q=%0d tc=%0b ov=%0b, expected q=%0d tc=%0b ov=%0b",
                 t, b_q, b_tc, b_overflow, e.q, e.tc, e.ov);
      end
    end
  end

  task automatic step_a(input string t, input logic rst, input logic clr, input logic ld,
                        input logic [5:0] lv, input logic en, input logic dir,
                        input logic [5:0] mx, input logic [5:0] eq, input logic etc,
                        input logic eov);
    @(negedge clk);
    a_reset = rst; a_clear = clr; a_load = ld; a_load_value = lv;
    a_enable = en; a_up = dir; a_max = mx;
    sb_a.push_back('{q: eq, tc: etc, ov: eov});
    tag_a.push_back(t);
  endtask

  task automatic step_b(input string t, input logic rst, input logic clr, input logic ld,
                        input logic [7:0] lv, input logic en, input logic dir,
                        input logic [7:0] mx, input logic [7:0] eq, input logic etc,
                        input logic eov);
    @(negedge clk);
    b_reset = rst; b_clear = clr; b_load = ld; b_load_value = lv;
    b_enable = en; b_up = dir; b_max = mx;
    sb_b.push_back('{q: eq, tc: etc, ov: eov});
    tag_b.push_back(t);
  endtask

  initial begin
    //            tag            rst clr ld  lv    en  up  max   q   tc  ov
    step_a("a_reset",          1,  0,  0,  6'd0, 1,  1,  6'd63, 0,  0,  0);
    for (int k = 1; k <= 70; k++)
      step_a("a_up_wrap63",    0,  0,  0,  6'd0, 1,  1,  6'd63, 6'(k % 64),
             k == 64, k >= 64);

    step_a("a_clear",          0,  1,  0,  6'd0, 0,  0,  6'd9,  0,  0,  0);
    step_a("a_load2",          0,  0,  1,  6'd2, 0,  0,  6'd9,  2,  0,  0);
    step_a("a_down1",          0,  0,  0,  6'd0, 1,  0,  6'd9,  1,  0,  0);
    step_a("a_down0",          0,  0,  0,  6'd0, 1,  0,  6'd9,  0,  0,  0);
    step_a("a_down_wrap9",     0,  0,  0,  6'd0, 1,  0,  6'd9,  9,  1,  1);
    step_a("a_down8",          0,  0,  0,  6'd0, 1,  0,  6'd9,  8,  0,  1);
    step_a("a_idle",           0,  0,  0,  6'd0, 0,  0,  6'd9,  8,  0,  1);

    step_a("a_clr_over_load",  0,  1,  1,  6'd17, 1, 1,  6'd63, 0,  0,  0);
    step_a("a_load_over_en",   0,  0,  1,  6'd17, 1, 1,  6'd63, 17, 0,  0);

    step_a("a_load36",         0,  0,  1,  6'd36, 0, 1,  6'd63, 36, 0,  0);
    step_a("a_count37",        0,  0,  0,  6'd0,  1, 1,  6'd63, 37, 0,  0);
    step_a("a_reset_mid",      1,  0,  0,  6'd0,  1, 1,  6'd63, 0,  0,  0);
    step_a("a_resume",         0,  0,  0,  6'd0,  1, 1,  6'd63, 1,  0,  0);

    step_a("a_load12",         0,  0,  1,  6'd12, 0, 1,  6'd9,  12, 0,  0);
    step_a("a_above_max_wrap", 0,  0,  0,  6'd0,  1, 1,  6'd9,  0,  1,  1);
    step_a("a_after_wrap",     0,  0,  0,  6'd0,  1, 1,  6'd9,  1,  0,  1);

    step_a("a_clear2",         0,  1,  0,  6'd0,  0, 1,  6'd0,  0,  0,  0);
    step_a("a_max0_step1",     0,  0,  0,  6'd0,  1, 1,  6'd0,  0,  1,  1);
    step_a("a_max0_step2",     0,  0,  0,  6'd0,  1, 1,  6'd0,  0,  1,  1);
    step_a("a_max0_idle",      0,  0,  0,  6'd0,  0, 1,  6'd0,  0,  0,  1);

    //            tag            rst clr ld  lv      en  up  max     q    tc  ov
    step_b("b_reset",          1,  0,  0,  8'd0,   0,  1,  8'd200, 0,   0,  0);
    step_b("b_load198",        0,  0,  1,  8'd198, 0,  1,  8'd200, 198, 0,  0);
    step_b("b_up199",          0,  0,  0,  8'd0,   1,  1,  8'd200, 199, 0,  0);
    step_b("b_up200",          0,  0,  0,  8'd0,   1,  1,  8'd200, 200, 0,  0);
    step_b("b_sat1",           0,  0,  0,  8'd0,   1,  1,  8'd200, 200, 1,  1);
    step_b("b_sat2",           0,  0,  0,  8'd0,   1,  1,  8'd200, 200, 1,  1);
    step_b("b_sat3",           0,  0,  0,  8'd0,   1,  1,  8'd200, 200, 1,  1);
    step_b("b_idle",           0,  0,  0,  8'd0,   0,  1,  8'd200, 200, 0,  1);
    step_b("b_load5",          0,  0,  1,  8'd5,   0,  0,  8'd200, 5,   0,  1);
    step_b("b_down4",          0,  0,  0,  8'd0,   1,  0,  8'd200, 4,   0,  1);
    step_b("b_clear",          0,  1,  0,  8'd0,   0,  0,  8'd200, 0,   0,  0);
    step_b("b_down_sat0",      0,  0,  0,  8'd0,   1,  0,  8'd200, 0,   1,  1);
    step_b("b_down_sat0_b",    0,  0,  0,  8'd0,   1,  0,  8'd200, 0,   1,  1);
    step_b("b_hold",           0,  0,  0,  8'd0,   0,  0,  8'd200, 0,   0,  1);

    begin
      int budget = 20;
      while ((sb_a.size() != 0 || sb_b.size() != 0) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (sb_a.size() != 0 || sb_b.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL drain: got %0d entries pending, expected 0", sb_a.size() + sb_b.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
